// File: rtl/inst_loader.sv
// inst_loader: receives a little-endian byte stream, assembles it into 32-bit
// instruction words and writes each word into instruction memory at
// consecutive word addresses.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, the words
// written in a session are XOR-folded and compared with the checksum supplied
// at start. err_o reports a mismatch.
module inst_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [31:0]   wr_data_o,
  output logic          busy_o,
  output logic          done_o,
  input  logic [31:0]   csum_i,
  output logic          err_o
);

  localparam int LW = AW + 1;
  localparam logic [AW:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   len_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    cnt_q;
  logic [31:0]   word_q;

  logic [AW:0]   len_clip;
  logic          accept;
  logic          last_word;

  // Requests longer than the memory are truncated so the address cannot wrap.
  assign len_clip  = (len_i > DEPTH_L) ? DEPTH_L : len_i;
  assign accept    = (state == RECV) && byte_valid_i;
  // Only evaluated in WRITE, where len_q is at least 1.
  assign last_word = ({1'b0, addr_q} == (len_q - LW'(1)));

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (len_clip == '0) ? DONE : RECV;
      RECV:    if (accept && cnt_q == 2'd3) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? DONE : RECV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs. start_i is only looked at in IDLE, so a start
  // while busy is ignored.
  always_comb begin
    byte_ready_o = (state == RECV);
    wr_en_o      = (state == WRITE);
    done_o       = (state == DONE);
    busy_o       = (state != IDLE);
  end

  assign wr_addr_o = addr_q;
  assign wr_data_o = word_q;

  // Session datapath: length latch, word address, byte lane counter and
  // word assembly. A reset discards a partial word because WRITE is the only
  // state that raises wr_en_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          len_q  <= len_clip;
          addr_q <= '0;
          cnt_q  <= '0;
        end
        RECV: if (accept) begin
          word_q[{cnt_q, 3'b000} +: 8] <= byte_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        // The address stays at the last word so it never passes DEPTH-1.
        WRITE: if (!last_word) addr_q <= addr_q + AW'(1);
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  logic [31:0] acc_q;
  logic        err_q;

  // Running XOR of the written words. The flag is updated on the edge that
  // enters DONE, so it is valid with done_o and holds until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          csum_q <= csum_i;
          acc_q  <= '0;
          err_q  <= (len_clip == '0) ? (csum_i != 32'd0) : 1'b0;
        end
        WRITE: begin
          acc_q <= acc_q ^ word_q;
          if (last_word) err_q <= ((acc_q ^ word_q) != csum_q);
        end
        default: ;
      endcase
    end
  end

  assign err_o = err_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter: DEPTH, 1024, instruction memory depth in 32-bit words (equals INST_MEM_ADDR_DEPTH).
REQ-002 Parameter: AW, 10, word-address width; DEPTH SHALL equal 2**AW.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start_i  input  1  one-cycle request to begin a load session.
REQ-006 Port: len_i  input  AW+1  number of words to load; sampled with start_i.
REQ-007 Port: byte_valid_i  input  1  byte_data_i valid.
REQ-008 Port: byte_data_i  input  8  incoming program byte, little-endian within a word.
REQ-009 Port: byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-010 Port: wr_en_o  output  1  one-cycle write strobe to the instruction memory.
REQ-011 Port: wr_addr_o  output  AW  word index written (pc offset >> 2).
REQ-012 Port: wr_data_o  output  32  assembled instruction word.
REQ-013 Port: busy_o  output  1  session in progress; core SHALL be held while high.
REQ-014 Port: done_o  output  1  one-cycle pulse at end of session.
REQ-015 Port: csum_i  input  32  expected XOR checksum; sampled with start_i.
REQ-016 Port: err_o  output  1  checksum mismatch flag, valid from the done_o pulse until the next start.

Function
REQ-017 FSM states SHALL be IDLE, RECV, WRITE and DONE.
REQ-018 IDLE: start_i=1 latches len (clipped to DEPTH) and csum_i, clears word address, byte count and checksum, then goes to RECV; with len_i=0 it goes directly to DONE.
REQ-019 RECV: byte_ready_o=1; a byte transfers when byte_valid_i and byte_ready_o are both high; byte k (0..3) SHALL land in bits [8k+7:8k].
REQ-020 Acceptance of the 4th byte in cycle N SHALL give wr_en_o=1 in cycle N+1 (WRITE state), with wr_addr_o and wr_data_o stable in that cycle.
REQ-021 WRITE lasts exactly one cycle; byte_ready_o=0; afterwards the address increments and the FSM returns to RECV, or goes to DONE if the word just written was word len-1.
REQ-022 DONE lasts one cycle with done_o=1, then returns to IDLE; busy_o=1 in RECV, WRITE and DONE.
REQ-023 start_i while busy_o=1 SHALL be ignored.
REQ-024 byte_valid_i outside RECV SHALL be ignored, and no byte is consumed.
REQ-025 Address SHALL never exceed DEPTH-1; with len=DEPTH the last write is at DEPTH-1.
REQ-026 wr_en_o SHALL never assert for a partially assembled word.

Reset
REQ-027 rst=1 SHALL force IDLE immediately: byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, err_o=0.
REQ-028 Reset mid-session SHALL discard the partial word with no further write; memory content already written is not restored.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN: when defined, a running XOR of all written words is compared with the latched csum at DONE, and err_o = (mismatch), registered with done_o.
REQ-030 Without LOADER_CHECKSUM_EN, csum_i SHALL be ignored and err_o SHALL be constant 0.

Verification
REQ-031 start_i, len=1; bytes 13,00,00,00 -> one wr_en_o pulse, addr 0, data 0x00000013, done_o one cycle later.
REQ-032 len=3, words 0x00500093, 0x00100113, 0x002081B3 with byte_valid gaps -> writes at addr 0,1,2 in order, byte_ready_o=0 during each WRITE cycle.
REQ-033 len=0 -> done_o pulses 1 cycle after start, wr_en_o never asserts.
REQ-034 rst asserted after 2 bytes of word 1 -> all outputs 0 within the same cycle, no write; a new session then starts at addr 0.
REQ-035 With LOADER_CHECKSUM_EN: words 0x11111111 and 0x22222222, csum_i=0x33333333 -> err_o=0; csum_i=0 -> err_o=1 with done_o.
REQ-036 len=DEPTH+5 -> exactly DEPTH writes, last at addr DEPTH-1, start_i pulses while busy ignored.
